mips_is_branch: RTL and testbench

- Branch-resolution block for the single-cycle MIPS datapath.
- Takes the 2-bit branch-type field from the control unit and the ALU zero flag, and decides whether the PC takes the branch target.
- Decision path is purely combinational, so the PC mux sees it in the same cycle.
- Adds a registered copy of the decision and saturating branch statistics counters for debug and performance monitoring.

---
 rtl/mips_pkg.sv | 10 +
 rtl/mips_sat_counter.sv | 24 ++
 rtl/mips_is_branch.sv | 67 ++++++
 tb/tb_mips_is_branch.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS single-cycle datapath blocks.
// Holds the control-unit branch-type encodings.
package mips_pkg;

    localparam logic [1:0] BR_NONE   = 2'b00;
    localparam logic [1:0] BR_EQ     = 2'b01;
    localparam logic [1:0] BR_NE     = 2'b10;
    localparam logic [1:0] BR_ALWAYS = 2'b11;

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter used for branch statistics.
// Ports: clk, clear (sync, highest priority), inc, count[CNT_W-1:0].
module mips_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_is_branch.sv
// Branch resolution: combinational taken decision plus a registered copy
// and saturating branch/taken counters.
// Ports: is_branch (comb out), branch[1:0], zero, valid, clk, rst (sync, high),
//        is_branch_q, branch_cnt, taken_cnt.
module mips_is_branch
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    output logic             is_branch,
    input  logic [1:0]       branch,
    input  logic             zero,
    input  logic             valid,
    input  logic             clk,
    input  logic             rst,
    output logic             is_branch_q,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic branch_inc;
    logic taken_inc;

    // Decision does not depend on clk, rst or valid so the PC mux
    // sees it in the same cycle, even during reset.
    always_comb begin
        is_branch = 1'b0;
        case (branch)
            BR_NONE:   is_branch = 1'b0;
            BR_EQ:     is_branch = zero;
            BR_NE:     is_branch = ~zero;
            BR_ALWAYS: is_branch = 1'b1;
            default:   is_branch = 1'bx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_branch_q <= 1'b0;
        end else begin
            is_branch_q <= valid & is_branch;
        end
    end

    // taken implies branch != NONE, so taken_cnt can never pass branch_cnt.
    assign branch_inc = valid & (branch != BR_NONE);
    assign taken_inc  = valid & is_branch;

    mips_sat_counter #(
        .CNT_W(CNT_W)
    ) u_branch_cnt (
        .clk  (clk),
        .clear(rst),
        .inc  (branch_inc),
        .count(branch_cnt)
    );

    mips_sat_counter #(
        .CNT_W(CNT_W)
    ) u_taken_cnt (
        .clk  (clk),
        .clear(rst),
        .inc  (taken_inc),
        .count(taken_cnt)
    );

endmodule

// File: tb/tb_mips_is_branch.sv
// Directed bench for mips_is_branch: a default-width instance and a
// 2-bit-counter instance driven by the same stimulus.
module tb_mips_is_branch;

    logic        clk;
    logic        rst;
    logic [1:0]  branch;
    logic        zero;
    logic        valid;

    logic        is_branch;
    logic        is_branch_q;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;

    logic        s_is_branch;
    logic        s_is_branch_q;
    logic [1:0]  s_branch_cnt;
    logic [1:0]  s_taken_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] tt_exp;

    mips_is_branch #(.CNT_W(16)) dut (
        .is_branch  (is_branch),
        .branch     (branch),
        .zero       (zero),
        .valid      (valid),
        .clk        (clk),
        .rst        (rst),
        .is_branch_q(is_branch_q),
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
    );

    mips_is_branch #(.CNT_W(2)) dut_s (
        .is_branch  (s_is_branch),
        .branch     (branch),
        .zero       (zero),
        .valid      (valid),
        .clk        (clk),
        .rst        (rst),
        .is_branch_q(s_is_branch_q),
        .branch_cnt (s_branch_cnt),
        .taken_cnt  (s_taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        branch = 2'b00;
        zero   = 1'b0;
        step();
        step();

        chk("rst_q",     32'(is_branch_q),  32'd0);
        chk("rst_bcnt",  32'(branch_cnt),   32'd0);
        chk("rst_tcnt",  32'(taken_cnt),    32'd0);
        chk("rst_s_bcnt", 32'(s_branch_cnt), 32'd0);
        chk("rst_s_tcnt", 32'(s_taken_cnt),  32'd0);

        // Truth table, {branch,zero} = 0..7 -> 0,0,0,1,1,0,1,1.
        rst    = 1'b0;
        tt_exp = 8'b1101_1000;
        for (int i = 0; i < 8; i++) begin
            {branch, zero} = 3'(i);
            #10;
            chk($sformatf("tt_%0d", i), 32'(is_branch), 32'(tt_exp[i]));
        end
        step();
        chk("tt_bcnt_hold", 32'(branch_cnt), 32'd0);

        // Registered path.
        valid  = 1'b1;
        branch = 2'b01;
        zero   = 1'b1;
        step();
        chk("reg_q1",   32'(is_branch_q), 32'd1);
        chk("reg_bcnt", 32'(branch_cnt),  32'd1);
        chk("reg_tcnt", 32'(taken_cnt),   32'd1);
        valid = 1'b0;
        step();
        chk("reg_q0", 32'(is_branch_q), 32'd0);

        // Counting after reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("cnt_clr_b", 32'(branch_cnt), 32'd0);
        chk("cnt_clr_t", 32'(taken_cnt),  32'd0);
        valid = 1'b1;
        branch = 2'b01; zero = 1'b1; step();
        branch = 2'b01; zero = 1'b0; step();
        branch = 2'b10; zero = 1'b0; step();
        branch = 2'b00; zero = 1'b1; step();
        branch = 2'b11; zero = 1'b0; step();
        chk("cnt_bcnt", 32'(branch_cnt),  32'd4);
        chk("cnt_tcnt", 32'(taken_cnt),   32'd3);
        chk("cnt_q",    32'(is_branch_q), 32'd1);

        // Valid gating.
        valid  = 1'b0;
        branch = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("gate_ib_%0d", i), 32'(is_branch),   32'd1);
            chk($sformatf("gate_b_%0d", i),  32'(branch_cnt),  32'd4);
            chk($sformatf("gate_t_%0d", i),  32'(taken_cnt),   32'd3);
            chk($sformatf("gate_q_%0d", i),  32'(is_branch_q), 32'd0);
        end

        // Saturation on the 2-bit instance.
        rst = 1'b1;
        step();
        rst   = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("sat_s_bcnt", 32'(s_branch_cnt), 32'd3);
        chk("sat_s_tcnt", 32'(s_taken_cnt),  32'd3);
        chk("sat_bcnt",   32'(branch_cnt),   32'd6);
        chk("sat_tcnt",   32'(taken_cnt),    32'd6);

        // Reset priority over valid.
        rst = 1'b1;
        step();
        chk("rp_q",      32'(is_branch_q),  32'd0);
        chk("rp_bcnt",   32'(branch_cnt),   32'd0);
        chk("rp_tcnt",   32'(taken_cnt),    32'd0);
        chk("rp_s_bcnt", 32'(s_branch_cnt), 32'd0);
        chk("rp_ib",     32'(is_branch),    32'd1);
        rst = 1'b0;
        step();
        chk("resume_bcnt", 32'(branch_cnt),  32'd1);
        chk("resume_tcnt", 32'(taken_cnt),   32'd1);
        chk("resume_q",    32'(is_branch_q), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
